// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - boot-time byte-stream loader for the core's instruction memory
//
// Accepts a byte stream over rx_data/rx_valid/rx_ready:
//   4 bytes len (little-endian word count), len data words, 4 bytes checksum (XOR of data words).
// Each assembled data word is written to IMEM at consecutive word addresses starting at 0.
// core_hold stays high until the image is loaded and the checksum matches.
//
// Ports:
//   clk, rst                 clock and asynchronous active-high reset
//   rx_data, rx_valid        incoming byte and its valid flag
//   rx_ready                 loader accepts a byte on this cycle's rising edge
//   imem_we/addr/wdata       IMEM write port, one-cycle strobe per word
//   core_hold                keep the core in reset while 1
//   load_done, load_err      terminal status (mutually exclusive)
//   words_loaded             number of words written so far
module imem_loader #(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              core_hold,
    output logic              load_done,
    output logic              load_err,
    output logic [ADDR_W:0]   words_loaded
);

    localparam logic [31:0] MAX_WORDS = 32'(1) << ADDR_W;

    typedef enum logic [2:0] {S_LEN, S_DATA, S_CSUM, S_DONE, S_ERR} state_t;

    state_t            state_q, state_d;
    logic [1:0]        byte_cnt_q, byte_cnt_d;
    logic [23:0]       part_q, part_d;        // lower three bytes of the word being assembled
    logic [31:0]       len_q, len_d;
    logic [31:0]       csum_acc_q, csum_acc_d;
    logic              rx_ready_q, rx_ready_d;
    logic              imem_we_q, imem_we_d;
    logic [ADDR_W-1:0] imem_addr_q, imem_addr_d;
    logic [31:0]       imem_wdata_q, imem_wdata_d;
    logic              core_hold_q, core_hold_d;
    logic              load_done_q, load_done_d;
    logic              load_err_q, load_err_d;
    logic [ADDR_W:0]   words_loaded_q, words_loaded_d;

    logic              accept;
    logic              last_byte;
    logic [31:0]       word;
    logic [ADDR_W:0]   wl_inc;

    always_comb begin
        accept    = rx_valid && rx_ready_q;
        last_byte = accept && (byte_cnt_q == 2'd3);
        // The 4th byte completes the word combinationally so it can be acted on this edge.
        word      = {rx_data, part_q};
        wl_inc    = words_loaded_q + 1'b1;

        state_d        = state_q;
        byte_cnt_d     = byte_cnt_q;
        part_d         = part_q;
        len_d          = len_q;
        csum_acc_d     = csum_acc_q;
        imem_we_d      = 1'b0;
        imem_addr_d    = imem_addr_q;
        imem_wdata_d   = imem_wdata_q;
        core_hold_d    = core_hold_q;
        load_done_d    = load_done_q;
        load_err_d     = load_err_q;
        words_loaded_d = words_loaded_q;

        if (accept) begin
            byte_cnt_d = byte_cnt_q + 2'd1;
            case (byte_cnt_q)
                2'd0:    part_d[7:0]   = rx_data;
                2'd1:    part_d[15:8]  = rx_data;
                2'd2:    part_d[23:16] = rx_data;
                default: ;
            endcase
        end

        if (last_byte) begin
            case (state_q)
                S_LEN: begin
                    len_d = word;
                    if (word == 32'd0 || word > MAX_WORDS) begin
                        state_d    = S_ERR;
                        load_err_d = 1'b1;
                    end else begin
                        state_d = S_DATA;
                    end
                end
                S_DATA: begin
                    imem_wdata_d   = word;
                    imem_addr_d    = words_loaded_q[ADDR_W-1:0];
                    imem_we_d      = 1'b1;
                    words_loaded_d = wl_inc;
                    csum_acc_d     = csum_acc_q ^ word;
                    if (32'(wl_inc) == len_q) begin
                        state_d = S_CSUM;
                    end
                end
                S_CSUM: begin
                    if (word == csum_acc_q) begin
                        state_d     = S_DONE;
                        load_done_d = 1'b1;
                        core_hold_d = 1'b0;
                    end else begin
                        state_d    = S_ERR;
                        load_err_d = 1'b1;
                    end
                end
                default: ;
            endcase
        end

        // Ready follows the next state so it drops on the same edge that enters a terminal state.
        rx_ready_d = (state_d == S_LEN) || (state_d == S_DATA) || (state_d == S_CSUM);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= S_LEN;
            byte_cnt_q     <= 2'd0;
            part_q         <= 24'd0;
            len_q          <= 32'd0;
            csum_acc_q     <= 32'd0;
            rx_ready_q     <= 1'b0;
            imem_we_q      <= 1'b0;
            imem_addr_q    <= '0;
            imem_wdata_q   <= 32'd0;
            core_hold_q    <= 1'b1;
            load_done_q    <= 1'b0;
            load_err_q     <= 1'b0;
            words_loaded_q <= '0;
        end else begin
            state_q        <= state_d;
            byte_cnt_q     <= byte_cnt_d;
            part_q         <= part_d;
            len_q          <= len_d;
            csum_acc_q     <= csum_acc_d;
            rx_ready_q     <= rx_ready_d;
            imem_we_q      <= imem_we_d;
            imem_addr_q    <= imem_addr_d;
            imem_wdata_q   <= imem_wdata_d;
            core_hold_q    <= core_hold_d;
            load_done_q    <= load_done_d;
            load_err_q     <= load_err_d;
            words_loaded_q <= words_loaded_d;
        end
    end

    assign rx_ready     = rx_ready_q;
    assign imem_we      = imem_we_q;
    assign imem_addr    = imem_addr_q;
    assign imem_wdata   = imem_wdata_q;
    assign core_hold    = core_hold_q;
    assign load_done    = load_done_q;
    assign load_err     = load_err_q;
    assign words_loaded = words_loaded_q;

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - self-checking bench for imem_loader
module tb_imem_loader;

    localparam int ADDR_W = 10;
    localparam int MAX_WORDS = 1 << ADDR_W;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [7:0]        rx_data = 8'd0;
    logic              rx_valid = 1'b0;
    logic              rx_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic              core_hold;
    logic              load_done;
    logic              load_err;
    logic [ADDR_W:0]   words_loaded;

    imem_loader #(.ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .core_hold(core_hold), .load_done(load_done), .load_err(load_err),
        .words_loaded(words_loaded)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0]          stream[$];
    logic [ADDR_W+31:0]  got_q[$];
    logic [ADDR_W+31:0]  exp_q[$];
    bit                  m_done, m_err;
    int                  m_acc;
    int                  we_double = 0;
    logic                prev_we = 1'b0;

    // Observe IMEM writes and flag any strobe longer than one cycle.
    always @(negedge clk) begin
        if (imem_we) got_q.push_back({imem_addr, imem_wdata});
        if (imem_we && prev_we) we_double++;
        prev_we = imem_we;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_rx_ready"}, 64'(rx_ready), 64'd0);
        chk({tag, "_imem_we"}, 64'(imem_we), 64'd0);
        chk({tag, "_imem_addr"}, 64'(imem_addr), 64'd0);
        chk({tag, "_imem_wdata"}, 64'(imem_wdata), 64'd0);
        chk({tag, "_core_hold"}, 64'(core_hold), 64'd1);
        chk({tag, "_done_err"}, 64'({load_done, load_err}), 64'd0);
        chk({tag, "_words"}, 64'(words_loaded), 64'd0);
    endtask

    // Called at a negedge; returns at a negedge with rx_ready already high.
    task automatic release_reset();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        got_q.delete();
        we_double = 0;
        chk("ready_after_reset", 64'(rx_ready), 64'd1);
    endtask

    task automatic do_reset(input bit check);
        @(negedge clk);
        rx_valid = 1'b0;
        rst = 1'b1;
        #1;
        if (check) chk_reset_outputs("reset");
        release_reset();
    endtask

    // Send bytes with random gaps; stops at the first byte that is never accepted.
    task automatic send(input int first, input int count, input int max_gap, output int acc);
        int waited;
        acc = 0;
        for (int i = first; i < first + count; i++) begin
            rx_valid = 1'b0;
            repeat ($urandom_range(0, max_gap)) @(negedge clk);
            rx_valid = 1'b1;
            rx_data  = stream[i];
            waited   = 0;
            while (!rx_ready && waited < 20) begin
                @(negedge clk);
                waited++;
            end
            if (!rx_ready) break;
            @(negedge clk);
            acc++;
        end
        rx_valid = 1'b0;
    endtask

    task automatic push_word(input logic [31:0] w);
        for (int k = 0; k < 4; k++) stream.push_back(w[8*k +: 8]);
    endtask

    task automatic build(input logic [31:0] len, input int nwords, input bit bad);
        logic [31:0] x;
        logic [31:0] w;
        x = 32'd0;
        stream.delete();
        push_word(len);
        for (int i = 0; i < nwords; i++) begin
            w = $urandom;
            x ^= w;
            push_word(w);
        end
        push_word(bad ? (x ^ (32'd1 << $urandom_range(0, 31))) : x);
    endtask

    // Reference: interpret the byte stream directly from the protocol rules.
    task automatic run_model();
        logic [31:0] len;
        logic [31:0] x;
        logic [31:0] w;
        logic [31:0] c;
        exp_q.delete();
        len = {stream[3], stream[2], stream[1], stream[0]};
        m_done = 1'b0;
        m_err  = 1'b0;
        if (len == 0 || len > MAX_WORDS) begin
            m_err = 1'b1;
            m_acc = 4;
        end else begin
            x = 32'd0;
            for (int i = 0; i < int'(len); i++) begin
                w = {stream[4*i+7], stream[4*i+6], stream[4*i+5], stream[4*i+4]};
                x ^= w;
                exp_q.push_back({ADDR_W'(i), w});
            end
            c = {stream[4*len+7], stream[4*len+6], stream[4*len+5], stream[4*len+4]};
            m_acc  = 8 + 4 * int'(len);
            m_done = (c == x);
            m_err  = !m_done;
        end
    endtask

    task automatic check_end(input string tag, input bit e_done, input bit e_err, input int e_nwr,
                             input int e_acc, input int acc);
        repeat (2) @(negedge clk);
        chk({tag, "_accepted"}, 64'(acc), 64'(e_acc));
        chk({tag, "_nwrites"}, 64'(got_q.size()), 64'(e_nwr));
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
            chk({tag, "_write"}, 64'(got_q[i]), 64'(exp_q[i]));
        chk({tag, "_load_done"}, 64'(load_done), 64'(e_done));
        chk({tag, "_load_err"}, 64'(load_err), 64'(e_err));
        chk({tag, "_core_hold"}, 64'(core_hold), 64'(!e_done));
        chk({tag, "_rx_ready"}, 64'(rx_ready), 64'd0);
        chk({tag, "_words"}, 64'(words_loaded), 64'(e_nwr));
        chk({tag, "_we_single"}, 64'(we_double), 64'd0);
    endtask

    typedef struct {
        string       name;
        logic [31:0] len;
        int          nwords;
        bit          bad;
        int          gap;
        bit          exp_done;
        bit          exp_err;
        int          exp_nwr;
    } vec_t;

    vec_t vecs[6];

    logic [7:0] nominal[16] = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h13, 8'h05, 8'hA0, 8'h00,
                               8'h93, 8'h05, 8'h10, 8'h00, 8'h80, 8'h00, 8'hB0, 8'h00};

    task automatic load_nominal(input logic [7:0] last);
        stream.delete();
        foreach (nominal[i]) stream.push_back(nominal[i]);
        stream[15] = last;
        exp_q.delete();
        exp_q.push_back({ADDR_W'(0), 32'h00A00513});
        exp_q.push_back({ADDR_W'(1), 32'h00100593});
    endtask

    initial begin
        int acc;
        int acc2;
        int nw;
        bit bad;

        vecs[0] = '{"len1",    32'd1,     1,    1'b0, 0, 1'b1, 1'b0, 1};
        vecs[1] = '{"len3gap", 32'd3,     3,    1'b0, 5, 1'b1, 1'b0, 3};
        vecs[2] = '{"badcsum", 32'd2,     2,    1'b1, 2, 1'b0, 1'b1, 2};
        vecs[3] = '{"len0",    32'd0,     2,    1'b0, 0, 1'b0, 1'b1, 0};
        vecs[4] = '{"len401",  32'h401,   2,    1'b0, 1, 1'b0, 1'b1, 0};
        vecs[5] = '{"lenmax",  32'd1024,  1024, 1'b0, 0, 1'b1, 1'b0, 1024};

        rst = 1'b1;
        #1;
        chk_reset_outputs("por");
        release_reset();

        // Nominal load, back-to-back bytes, then trailing bytes after S_DONE.
        load_nominal(8'h00);
        send(0, 16, 0, acc);
        check_end("nominal", 1'b1, 1'b0, 2, 16, acc);
        send(0, 3, 0, acc2);
        chk("trail_accepted", 64'(acc2), 64'd0);
        chk("trail_nwrites", 64'(got_q.size()), 64'd2);
        chk("trail_done", 64'({load_done, load_err, core_hold}), 64'b100);
        chk("trail_words", 64'(words_loaded), 64'd2);

        // Bad checksum on the fixed stream.
        do_reset(1'b1);
        load_nominal(8'h01);
        send(0, 16, 0, acc);
        check_end("nominal_bad", 1'b0, 1'b1, 2, 16, acc);

        // Nominal stream with random gaps.
        do_reset(1'b0);
        load_nominal(8'h00);
        send(0, 16, 5, acc);
        check_end("nominal_gaps", 1'b1, 1'b0, 2, 16, acc);

        // Reset in the middle of the second data word, then a full replay.
        do_reset(1'b0);
        load_nominal(8'h00);
        send(0, 10, 0, acc);
        chk("mid_words_before", 64'(words_loaded), 64'd1);
        #3;
        rst = 1'b1;
        #1;
        chk_reset_outputs("mid_reset");
        release_reset();
        send(0, 16, 2, acc);
        check_end("replay", 1'b1, 1'b0, 2, 16, acc);

        // Table-driven vectors.
        foreach (vecs[v]) begin
            do_reset(1'b0);
            build(vecs[v].len, vecs[v].nwords, vecs[v].bad);
            run_model();
            send(0, stream.size(), vecs[v].gap, acc);
            check_end(vecs[v].name, vecs[v].exp_done, vecs[v].exp_err, vecs[v].exp_nwr, m_acc, acc);
        end

        // Randomized loads against the model.
        for (int t = 0; t < 8; t++) begin
            do_reset(1'b0);
            nw  = $urandom_range(1, 6);
            bad = ($urandom_range(0, 3) == 0);
            build(32'(nw), nw, bad);
            run_model();
            send(0, stream.size(), $urandom_range(0, 5), acc);
            check_end("random", m_done, m_err, exp_q.size(), m_acc, acc);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
